// File: rtl/gam_sel_arbiter_if.sv
// gam_sel_arbiter_if: requester/consumer bus between the round-robin arbiter and its peers.
// master is the arbiter side; slave is the requester/consumer side.
interface gam_sel_arbiter_if;
    logic [3:0] req_valid;
    logic [3:0] req_last;
    logic [3:0] req_ready;
    logic       out_ready;
    logic       out_valid;
    logic       out_last;
    logic [1:0] select;
    logic [3:0] grant;
    logic       busy;
    logic       forced_release;
    modport master (
        input  req_valid, req_last, out_ready,
        output req_ready, out_valid, out_last, select, grant, busy, forced_release
    );
    modport slave (
        output req_valid, req_last, out_ready,
        input  req_ready, out_valid, out_last, select, grant, busy, forced_release
    );
endinterface

// File: rtl/gam_sel_arbiter.sv
// gam_sel_arbiter: round-robin grant of one of four beat streams onto the 4:1 mux select,
// ending each grant on last beat, burst cap or stall timeout.
module gam_sel_arbiter #(
    parameter int MAX_BURST     = 8,
    parameter int STALL_TIMEOUT = 16
) (
    input logic               clk,
    input logic               reset_n,
    gam_sel_arbiter_if.master bus
);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int SW = $clog2(STALL_TIMEOUT + 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t          state_q, state_d;
    logic [1:0]      rr_ptr_q, rr_ptr_d;
    logic [1:0]      select_q, select_d;
    logic [3:0]      grant_q, grant_d;
    logic [BW-1:0]   beat_cnt_q, beat_cnt_d;
    logic [SW-1:0]   stall_cnt_q, stall_cnt_d;
    logic            forced_q, forced_d;
    logic [1:0]      pick;
    logic            busy, live, vs, ls, cap, stall_hit, xfer, rel;

    always_comb begin
        pick = rr_ptr_q;
        for (int k = 3; k >= 0; k--)
            if (bus.req_valid[rr_ptr_q + 2'(k)]) pick = rr_ptr_q + 2'(k);
    end

    // Handshake outputs are masked while reset is asserted so a mid-burst reset moves no beat.
    always_comb begin
        busy          = state_q == GRANT;
        live          = busy && reset_n;
        vs            = bus.req_valid[select_q];
        ls            = bus.req_last[select_q];
        cap           = beat_cnt_q == BW'(MAX_BURST - 1);
        stall_hit     = busy && !vs && stall_cnt_q == SW'(STALL_TIMEOUT - 1);
        bus.out_valid = live && vs;
        bus.out_last  = live && vs && (ls || cap);
        bus.req_ready = (live && bus.out_ready) ? 4'b0001 << select_q : 4'b0000;
        xfer          = bus.out_valid && bus.out_ready;
        rel           = (xfer && bus.out_last) || stall_hit;
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        select_d    = select_q;
        grant_d     = grant_q;
        beat_cnt_d  = beat_cnt_q;
        stall_cnt_d = stall_cnt_q;
        forced_d    = 1'b0;
        if (!busy) begin
            beat_cnt_d  = '0;
            stall_cnt_d = '0;
            if (|bus.req_valid) begin
                state_d  = GRANT;
                select_d = pick;
                grant_d  = 4'b0001 << pick;
            end
        end else if (rel) begin
            state_d     = IDLE;
            grant_d     = '0;
            rr_ptr_d    = select_q + 2'd1;
            forced_d    = stall_hit || !ls;
            beat_cnt_d  = '0;
            stall_cnt_d = '0;
        end else begin
            beat_cnt_d  = beat_cnt_q + BW'(xfer);
            stall_cnt_d = vs ? '0 : stall_cnt_q + SW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            select_q    <= '0;
            grant_q     <= '0;
            beat_cnt_q  <= '0;
            stall_cnt_q <= '0;
            forced_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            select_q    <= select_d;
            grant_q     <= grant_d;
            beat_cnt_q  <= beat_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            forced_q    <= forced_d;
        end
    end

    assign bus.select         = select_q;
    assign bus.grant          = grant_q;
    assign bus.busy           = busy;
    assign bus.forced_release = forced_q;
endmodule

// File: tb/tb_gam_sel_arbiter.sv
// tb_gam_sel_arbiter: directed scenarios for the round-robin select arbiter.
// Observed vector is {grant, select, busy, out_valid, out_last, req_ready, forced_release}.
module tb_gam_sel_arbiter;
    logic clk = 1'b0;
    logic reset_n;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    gam_sel_arbiter_if ifc();

    gam_sel_arbiter #(.MAX_BURST(8), .STALL_TIMEOUT(16)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (ifc)
    );

    wire [13:0] obs = {ifc.grant, ifc.select, ifc.busy, ifc.out_valid, ifc.out_last,
                       ifc.req_ready, ifc.forced_release};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n       = 1'b0;
        ifc.req_valid = 4'hF;
        ifc.req_last  = 4'hF;
        ifc.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            if (obs !== 14'b0) begin
                bad++;
                $display("FAIL reset_hold[%0d]: got %b want %b", i, obs, 14'b0);
            end
            total++;
        end
    endtask

    task automatic test_rotation();
        logic [13:0] exp;
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            exp = {4'(1 << (i % 4)), 2'(i % 4), 1'b1, 1'b1, 1'b1, 4'(1 << (i % 4)), 1'b0};
            if (obs !== exp) begin
                bad++;
                $display("FAIL rotation_grant[%0d]: got %b want %b", i, obs, exp);
            end
            total++;
            step();
            exp = {4'b0000, 2'(i % 4), 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0};
            if (obs !== exp) begin
                bad++;
                $display("FAIL rotation_bubble[%0d]: got %b want %b", i, obs, exp);
            end
            total++;
            if (i == 4) ifc.req_valid = 4'h0;
        end
        ifc.req_last = 4'h0;
        step();
    endtask

    task automatic test_burst_cap();
        logic [13:0] exp;
        ifc.req_valid = 4'b0101;
        step();
        for (int b = 0; b < 8; b++) begin
            exp = {4'b0100, 2'd2, 1'b1, 1'b1, 1'(b == 7), 4'b0100, 1'b0};
            if (obs !== exp) begin
                bad++;
                $display("FAIL cap_beat[%0d]: got %b want %b", b, obs, exp);
            end
            total++;
            step();
        end
        exp = {4'b0000, 2'd2, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1};
        if (obs !== exp) begin
            bad++;
            $display("FAIL cap_pulse: got %b want %b", obs, exp);
        end
        total++;
        step();
        for (int b = 0; b < 8; b++) begin
            ifc.req_last = (b == 7) ? 4'b0001 : 4'b0000;
            #1;
            exp = {4'b0001, 2'd0, 1'b1, 1'b1, 1'(b == 7), 4'b0001, 1'b0};
            if (obs !== exp) begin
                bad++;
                $display("FAIL simul_beat[%0d]: got %b want %b", b, obs, exp);
            end
            total++;
            step();
        end
        exp = {4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0};
        if (obs !== exp) begin
            bad++;
            $display("FAIL simul_no_pulse: got %b want %b", obs, exp);
        end
        total++;
        ifc.req_valid = 4'h0;
        ifc.req_last  = 4'h0;
        step();
    endtask

    task automatic test_backpressure();
        logic [13:0] exp;
        ifc.req_valid = 4'b0010;
        ifc.out_ready = 1'b0;
        step();
        for (int c = 0; c < 40; c++) begin
            exp = {4'b0010, 2'd1, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0};
            if (obs !== exp) begin
                bad++;
                $display("FAIL backpressure[%0d]: got %b want %b", c, obs, exp);
            end
            total++;
            step();
        end
        ifc.out_ready = 1'b1;
        ifc.req_last  = 4'b0010;
        #1;
        exp = {4'b0010, 2'd1, 1'b1, 1'b1, 1'b1, 4'b0010, 1'b0};
        if (obs !== exp) begin
            bad++;
            $display("FAIL bp_resume: got %b want %b", obs, exp);
        end
        total++;
        step();
        exp = {4'b0000, 2'd1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0};
        if (obs !== exp) begin
            bad++;
            $display("FAIL bp_release: got %b want %b", obs, exp);
        end
        total++;
        ifc.req_valid = 4'h0;
        ifc.req_last  = 4'h0;
        step();
    endtask

    task automatic test_stall_timeout();
        logic [13:0] exp;
        ifc.req_valid = 4'b1000;
        step();
        ifc.req_valid = 4'b0000;
        #1;
        for (int c = 0; c < 16; c++) begin
            exp = {4'b1000, 2'd3, 1'b1, 1'b0, 1'b0, 4'b1000, 1'b0};
            if (obs !== exp) begin
                bad++;
                $display("FAIL stall_wait[%0d]: got %b want %b", c, obs, exp);
            end
            total++;
            step();
        end
        exp = {4'b0000, 2'd3, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1};
        if (obs !== exp) begin
            bad++;
            $display("FAIL stall_pulse: got %b want %b", obs, exp);
        end
        total++;
        ifc.req_valid = 4'b1010;
        ifc.req_last  = 4'b0010;
        step();
        exp = {4'b0010, 2'd1, 1'b1, 1'b1, 1'b1, 4'b0010, 1'b0};
        if (obs !== exp) begin
            bad++;
            $display("FAIL stall_rr_wrap: got %b want %b", obs, exp);
        end
        total++;
        step();
        exp = {4'b0000, 2'd1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0};
        if (obs !== exp) begin
            bad++;
            $display("FAIL stall_after: got %b want %b", obs, exp);
        end
        total++;
        ifc.req_valid = 4'h0;
        ifc.req_last  = 4'h0;
        step();
    endtask

    task automatic test_reset_mid_burst();
        logic [13:0] exp;
        ifc.req_valid = 4'b0100;
        step();
        for (int b = 0; b < 3; b++) begin
            exp = {4'b0100, 2'd2, 1'b1, 1'b1, 1'b0, 4'b0100, 1'b0};
            if (obs !== exp) begin
                bad++;
                $display("FAIL mid_beat[%0d]: got %b want %b", b, obs, exp);
            end
            total++;
            step();
        end
        reset_n = 1'b0;
        #1;
        exp = {4'b0100, 2'd2, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0};
        if (obs !== exp) begin
            bad++;
            $display("FAIL mid_reset_cycle: got %b want %b", obs, exp);
        end
        total++;
        step();
        if (obs !== 14'b0) begin
            bad++;
            $display("FAIL mid_after_reset: got %b want %b", obs, 14'b0);
        end
        total++;
        ifc.req_valid = 4'hF;
        reset_n       = 1'b1;
        step();
        for (int b = 0; b < 8; b++) begin
            exp = {4'b0001, 2'd0, 1'b1, 1'b1, 1'(b == 7), 4'b0001, 1'b0};
            if (obs !== exp) begin
                bad++;
                $display("FAIL mid_regrant[%0d]: got %b want %b", b, obs, exp);
            end
            total++;
            step();
        end
        exp = {4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1};
        if (obs !== exp) begin
            bad++;
            $display("FAIL mid_regrant_pulse: got %b want %b", obs, exp);
        end
        total++;
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_burst_cap();
        test_backpressure();
        test_stall_timeout();
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
